// File: rtl/sobel_mul_share_arb.sv
// -----------------------------------------------------------------------------
// sobel_mul_share_arb
//
// Shares one pipelined unsigned multiplier (A_W x B_W) among N_REQ requesters
// of the Sobel gradient/normalisation path. Requests are granted round-robin.
// Tagged products come back, in acceptance order, on one shared response port
// that supports backpressure.
//
// Ports
//   ap_clk     clock, all state on the rising edge
//   ap_rst_n   asynchronous active-low reset
//   req_valid  [N_REQ]      requester i presents operands
//   req_ready  [N_REQ]      requester i accepted this cycle (one-hot or zero)
//   req_a      [N_REQ*A_W]  operand A of requester i at [i*A_W +: A_W]
//   req_b      [N_REQ*B_W]  operand B of requester i at [i*B_W +: B_W]
//   rsp_valid  result available
//   rsp_ready  consumer accepts the result
//   rsp_id     [ID_W]       index of the requester that issued the result
//   rsp_p      [P_W]        product, (A*B) mod 2^P_W
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// 1. req_ready may depend combinationally on req_valid in the same cycle.
// While rsp_valid=1 and rsp_ready=0, rsp_id/rsp_p hold. The whole pipeline
// stalls, rr_ptr holds, and all req_ready bits are 0.
//
// Pipeline: stage 0 holds the registered operands. Stage 1 holds the
// registered product. Further stages delay the product. The last stage is the
// response register. A request accepted at edge t is presented on rsp_* after
// edge t+MUL_STAGES+1. Valid and tag travel alongside the data.
// -----------------------------------------------------------------------------
module sobel_mul_share_arb #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int A_W        = 8,
    parameter int B_W        = 22,
    parameter int P_W        = 29,
    parameter int MUL_STAGES = 2
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*A_W-1:0]   req_a,
    input  logic [N_REQ*B_W-1:0]   req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [ID_W-1:0]        rsp_id,
    output logic [P_W-1:0]         rsp_p
);

    // Registers after stage 0. The last one is the response register.
    localparam int DEPTH = MUL_STAGES + 1;
    localparam int M_W   = A_W + B_W;

    logic              advance;
    logic [ID_W-1:0]   rr_ptr;

    // Arbitration results
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_id;
    logic              found;
    logic [A_W-1:0]    sel_a;
    logic [B_W-1:0]    sel_b;
    logic [ID_W-1:0]   next_ptr;
    int                idx;

    // Stage 0: operand register
    logic              v0;
    logic [A_W-1:0]    a0;
    logic [B_W-1:0]    b0;
    logic [ID_W-1:0]   id0;
    logic [P_W-1:0]    prod;

    // Stages 1..DEPTH
    logic [DEPTH:1]    v_pipe;
    logic [ID_W-1:0]   id_pipe [1:DEPTH];
    logic [P_W-1:0]    p_pipe  [1:DEPTH];

    assign advance = ~(rsp_valid & ~rsp_ready);

    // Search rr_ptr, rr_ptr+1, ... (mod N_REQ) for the first valid requester.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        sel_a    = '0;
        sel_b    = '0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
                sel_a      = req_a[idx*A_W +: A_W];
                sel_b      = req_b[idx*B_W +: B_W];
            end
        end
    end

    assign next_ptr  = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    // Gated by reset so that no requester sees an accept while in reset.
    assign req_ready = (advance && ap_rst_n) ? grant : '0;

    // Form the full product, then keep only the low P_W bits.
    assign prod = P_W'(M_W'(a0) * M_W'(b0));

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr <= '0;
            v0     <= 1'b0;
            a0     <= '0;
            b0     <= '0;
            id0    <= '0;
            v_pipe <= '0;
            for (int s = 1; s <= DEPTH; s++) begin
                id_pipe[s] <= '0;
                p_pipe[s]  <= '0;
            end
        end else if (advance) begin
            v0 <= found;
            if (found) begin
                a0     <= sel_a;
                b0     <= sel_b;
                id0    <= grant_id;
                rr_ptr <= next_ptr;
            end
            v_pipe[1]  <= v0;
            id_pipe[1] <= id0;
            p_pipe[1]  <= prod;
            for (int s = 2; s <= DEPTH; s++) begin
                v_pipe[s]  <= v_pipe[s-1];
                id_pipe[s] <= id_pipe[s-1];
                p_pipe[s]  <= p_pipe[s-1];
            end
        end
    end

    assign rsp_valid = v_pipe[DEPTH];
    assign rsp_id    = id_pipe[DEPTH];
    assign rsp_p     = p_pipe[DEPTH];

endmodule
